arbiter_wrr_packet: RTL and testbench

- Packet-level weighted round-robin arbiter that shares one valid/ready output stream between REQ_WIDTH requesters.
- Ownership is granted per requester and held for whole packets, up to a per-requester packet budget (weight), then rotates.
- Sits in front of a shared single-port sink (bus master port, FIFO write side).
- Data, last and ready are multiplexed by the registered owner.

---
 rtl/arbiter_wrr_packet_if.sv | 33 +++
 rtl/arbiter_wrr_packet.sv | 135 +++++++++++++
 tb/tb_arbiter_wrr_packet.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_wrr_packet_if.sv
// Stream bundle for the packet WRR arbiter:
// per-requester inputs, shared output stream and grant status.
interface arbiter_wrr_packet_if #(
  parameter int REQ_WIDTH    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 4
);
  logic [REQ_WIDTH-1:0]              req_valid;
  logic [REQ_WIDTH-1:0]              req_last;
  logic [REQ_WIDTH*DATA_WIDTH-1:0]   req_data;
  logic [REQ_WIDTH-1:0]              req_ready;
  logic [REQ_WIDTH*WEIGHT_WIDTH-1:0] weight;
  logic                              out_valid;
  logic [DATA_WIDTH-1:0]             out_data;
  logic                              out_last;
  logic                              out_ready;
  logic [REQ_WIDTH-1:0]              gnt;
  logic                              busy;

  modport master (
    output req_valid, req_last, req_data,
    output weight, out_ready,
    input  req_ready, out_valid, out_data,
    input  out_last, gnt, busy
  );

  modport slave (
    input  req_valid, req_last, req_data,
    input  weight, out_ready,
    output req_ready, out_valid, out_data,
    output out_last, gnt, busy
  );
endinterface

// File: rtl/arbiter_wrr_packet.sv
// Packet-level weighted round-robin arbiter: one owner holds the
// shared stream for up to weight[owner] whole packets, then rotates.
module arbiter_wrr_packet #(
  parameter int REQ_WIDTH    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 4
) (
  input logic clk,
  input logic rst_n,
  arbiter_wrr_packet_if.slave bus
);
  localparam int IW = (REQ_WIDTH > 1) ? $clog2(REQ_WIDTH) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                  state_q;
  logic [REQ_WIDTH-1:0]    gnt_q;
  logic [REQ_WIDTH-1:0]    gnt_d;
  logic [IW-1:0]           own_q;
  logic [IW-1:0]           ptr_q;
  logic [WEIGHT_WIDTH-1:0] credit_q;
  logic                    in_pkt_q;

  logic                    own_valid;
  logic                    own_last;
  logic                    own_req;
  logic [DATA_WIDTH-1:0]   own_data;
  logic                    fire;
  logic                    rel;

  logic [REQ_WIDTH-1:0]    cand;
  logic [IW-1:0]           base;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           pick_idx;
  logic                    pick_vld;
  logic [IW-1:0]           load_idx;
  logic [WEIGHT_WIDTH-1:0] load_w;

  assign own_valid = |(bus.req_valid & gnt_q);
  assign own_last  = |(bus.req_last & gnt_q);
  assign own_req   = bus.req_valid[own_q];
  assign fire      = own_valid & bus.out_ready;

  always_comb begin
    own_data = '0;
    for (int i = 0; i < REQ_WIDTH; i++)
      if (gnt_q[i])
        own_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign rel = (state_q == GRANT) &
               ((fire & own_last & (credit_q == WEIGHT_WIDTH'(1))) |
                (~in_pkt_q & ~fire & ~own_valid));

  // At release the previous owner is excluded and searched from above.
  always_comb begin
    base = (state_q == GRANT) ? own_q : ptr_q;
    cand = bus.req_valid;
    if (state_q == GRANT)
      cand[own_q] = 1'b0;
    idx      = '0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = REQ_WIDTH; k >= 1; k--) begin
      idx = IW'((int'(base) + k) % REQ_WIDTH);
      if (cand[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  assign load_idx = pick_vld ? pick_idx : own_q;
  assign gnt_d    = {{(REQ_WIDTH-1){1'b0}}, 1'b1} << load_idx;

  always_comb begin
    load_w = '0;
    for (int i = 0; i < REQ_WIDTH; i++)
      if (IW'(i) == load_idx)
        load_w = bus.weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    if (load_w == '0)
      load_w = WEIGHT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      own_q    <= '0;
      ptr_q    <= IW'(REQ_WIDTH-1);
      credit_q <= '0;
      in_pkt_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q  <= GRANT;
            gnt_q    <= gnt_d;
            own_q    <= load_idx;
            credit_q <= load_w;
          end
        end
        GRANT: begin
          if (fire & own_last) begin
            in_pkt_q <= 1'b0;
            credit_q <= credit_q - WEIGHT_WIDTH'(1);
          end else if (fire) begin
            in_pkt_q <= 1'b1;
          end
          if (rel) begin
            ptr_q    <= own_q;
            in_pkt_q <= 1'b0;
            if (pick_vld | own_req) begin
              gnt_q    <= gnt_d;
              own_q    <= load_idx;
              credit_q <= load_w;
            end else begin
              state_q  <= IDLE;
              gnt_q    <= '0;
              credit_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = gnt_q & {REQ_WIDTH{bus.out_ready}};
  assign bus.out_valid = own_valid;
  assign bus.out_data  = own_data;
  assign bus.out_last  = own_last;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = |gnt_q;
endmodule

// File: tb/tb_arbiter_wrr_packet.sv
// Bench for arbiter_wrr_packet: directed scenarios plus random
// traffic checked against a packet-level reference model.
module tb_arbiter_wrr_packet;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arbiter_wrr_packet_if #(
    .REQ_WIDTH(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)
  ) bus ();

  arbiter_wrr_packet #(
    .REQ_WIDTH(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [N-1:0] v;
  logic [N-1:0] l;
  logic         ordy;
  bit           rnd;
  int           wt[N];
  int           seq[N];
  int           rem[N];
  int           fires0;
  logic [N-1:0] g_obs;
  logic [N-1:0] r_obs;

  // reference model: owner (-1 idle), packets left, in-packet, last owner
  int m_own;
  int m_cred;
  bit m_inpkt;
  int m_prev;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(int i);
    return DW'((i << 24) | (seq[i] & 32'h00ff_ffff));
  endfunction

  function automatic int eff(int w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int pick(logic [N-1:0] m, int prev, int excl);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (prev + k) % N;
      if (m[j] && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(int o);
    logic [N-1:0] r;
    r = '0;
    if (o >= 0) r[o] = 1'b1;
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_data[i*DW +: DW] = dat(i);
      bus.weight[i*WW +: WW]   = WW'(wt[i]);
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.out_ready = ordy;
  endtask

  task automatic gen();
    for (int i = 0; i < N; i++) begin
      if (rem[i] == 0 && $urandom_range(0, 2) == 0)
        rem[i] = $urandom_range(1, 4);
      v[i] = (rem[i] > 0 && $urandom_range(0, 3) != 0);
      l[i] = (rem[i] == 1);
    end
    ordy = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 15) == 0)
      wt[$urandom_range(0, N-1)] = $urandom_range(0, 3);
  endtask

  task automatic cycle();
    logic [N-1:0] eg;
    logic [N-1:0] er;
    bit ev;
    bit fire;
    bit rel;
    int o;
    int s;
    @(negedge clk);
    if (rnd) gen();
    drive();
    #1;
    o  = m_own;
    eg = oh(o);
    er = ordy ? eg : '0;
    ev = 1'b0;
    if (o >= 0) ev = v[o];
    g_obs = bus.gnt;
    r_obs = bus.req_ready;
    chk("gnt", bus.gnt, eg);
    chk("busy", bus.busy, (o >= 0));
    chk("req_ready", bus.req_ready, er);
    chk("out_valid", bus.out_valid, ev);
    if (ev) begin
      chk("out_data", bus.out_data, dat(o));
      chk("out_last", bus.out_last, l[o]);
    end
    if (bus.out_valid && bus.out_ready && bus.gnt[0]) fires0++;
    fire = ev && ordy;
    if (o < 0) begin
      s = pick(v, m_prev, -1);
      if (s >= 0) begin
        m_own  = s;
        m_cred = eff(wt[s]);
      end
    end else begin
      rel = 1'b0;
      if (fire && l[o]) begin
        m_cred--;
        m_inpkt = 1'b0;
        rel = (m_cred == 0);
      end else if (fire) begin
        m_inpkt = 1'b1;
      end else if (!m_inpkt && !v[o]) begin
        rel = 1'b1;
      end
      if (rel) begin
        s = pick(v, o, o);
        m_prev  = o;
        m_inpkt = 1'b0;
        if (s < 0 && v[o]) s = o;
        m_own = s;
        if (s >= 0) m_cred = eff(wt[s]);
      end
    end
    if (fire) begin
      seq[o]++;
      if (rem[o] > 0) rem[o]--;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    m_own = -1; m_cred = 0; m_inpkt = 1'b0; m_prev = N - 1;
    v = '0; l = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_seq(string tag, input int e[$]);
    foreach (e[k]) begin
      cycle();
      chk(tag, g_obs, oh(e[k]));
    end
  endtask

  initial begin
    int q[$];
    int s0;
    v = '0; l = '0; ordy = 1'b1; rnd = 1'b0; fires0 = 0;
    for (int i = 0; i < N; i++) begin
      wt[i] = 1; seq[i] = 0; rem[i] = 0;
    end
    m_own = -1; m_cred = 0; m_inpkt = 1'b0; m_prev = N - 1;
    drive();
    do_reset();

    // two requesters, one-beat packets, back-to-back handover
    v = 4'b0110; l = 4'b1111;
    q = {-1, 1, 2, 1, 2};
    run_seq("t1_gnt", q);

    // weights {1,2,1,3}, all requesting
    do_reset();
    wt[0] = 1; wt[1] = 2; wt[2] = 1; wt[3] = 3;
    v = 4'b1111; l = 4'b1111;
    q = {-1, 0, 1, 1, 2, 3, 3, 3, 0, 1};
    run_seq("t2_gnt", q);

    // 3-beat packet with ready toggling and a bubble
    do_reset();
    for (int i = 0; i < N; i++) wt[i] = 1;
    fires0 = 0;
    s0 = seq[0];
    for (int c = 0; c < 6; c++) begin
      ordy = (c == 2 || c == 4) ? 1'b0 : 1'b1;
      v = 4'b0010;
      v[0] = ((seq[0] - s0) < 3) && (c != 2);
      l = 4'b0010;
      l[0] = ((seq[0] - s0) == 2);
      cycle();
      if (c > 0) begin
        chk("t3_hold", g_obs, 4'b0001);
        chk("t3_rdy1", r_obs[1], 1'b0);
      end
    end
    chk("t3_beats", fires0, 3);
    v = 4'b0010; l = 4'b0010; ordy = 1'b1;
    cycle();
    chk("t3_next", g_obs, 4'b0010);

    // owner with spare credit goes idle, waiting requester takes over
    do_reset();
    wt[2] = 4;
    v = 4'b0100; l = 4'b0100;
    q = {-1, 2};
    run_seq("t4_gnt", q);
    v = 4'b1000; l = 4'b1000;
    q = {2, 3};
    run_seq("t4_rel", q);

    // zero weight behaves as one
    do_reset();
    wt[0] = 2; wt[1] = 0; wt[2] = 1; wt[3] = 1;
    v = 4'b1111; l = 4'b1111;
    q = {-1, 0, 0, 1, 2, 3, 0, 0, 1};
    run_seq("t5_gnt", q);

    // reset in the middle of a 4-beat packet
    do_reset();
    for (int i = 0; i < N; i++) wt[i] = 1;
    v = 4'b0001; l = 4'b0000;
    q = {-1, 0, 0};
    run_seq("t6_pre", q);
    do_reset();
    v = 4'b0101; l = 4'b0101;
    q = {-1, 0, 2};
    run_seq("t6_post", q);

    // random traffic against the model
    do_reset();
    rnd = 1'b1;
    repeat (800) cycle();
    rnd = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
